// File: rtl/serial_parity_rx.sv
// serial_parity_rx: start/data(LSB first)/even-parity/stop frame receiver with valid and error flags
module serial_parity_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic              pbit_q, pbit_d, perr_q, perr_d, ferr_q, ferr_d;
  logic              rx_meta_q, rxs_q, rxs_prev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      pbit_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      pbit_q     <= pbit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end
  // A start needs a high-to-low transition, so a line left low after a bad stop bit cannot restart
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    pbit_d  = pbit_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = (!rxs_q && rxs_prev_q) ? START : IDLE;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxs_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d   = '0;
        shift_d = {rxs_q, shift_q[DATA_W-1:1]};
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == LAST) ? PARITY : DATA;
      end
      PARITY: if (cnt_q == FULL) begin
        cnt_d   = '0;
        pbit_d  = rxs_q;
        state_d = STOP;
      end
      STOP: if (cnt_q == FULL) begin
        cnt_d   = '0;
        data_d  = shift_q;
        perr_d  = ~((^shift_q) ~^ pbit_q);
        ferr_d  = ~rxs_q;
        state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign done       = (state_q == DONE);
  assign valid      = done & ~perr_q & ~ferr_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx: directed and randomized frames scored against a frame-level reference model
module tb_serial_parity_rx;
  localparam int DW  = 8;
  localparam int CPB = 16;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DW-1:0] data_out;
  logic          done, valid, parity_err, frame_err, busy;
  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
    logic          v;
  } rec_t;
  rec_t got_q[$], exp_q[$];
  rec_t mon_r;
  int   checks = 0;
  int   errors = 0;
  serial_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .done(done),
    .valid(valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst && done) begin
    mon_r.d  = data_out;
    mon_r.pe = parity_err;
    mon_r.fe = frame_err;
    mon_r.v  = valid;
    got_q.push_back(mon_r);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input int abort_at = -1);
    rec_t e;
    for (int k = 0; k < DW + 3; k++) begin
      if (k == abort_at) begin
        repeat (CPB / 2) @(negedge clk);
        return;
      end
      rx = (k == 0) ? 1'b0 : (k <= DW) ? d[k-1] : (k == DW + 1) ? p : s;
      repeat (CPB) @(negedge clk);
    end
    e.d  = d;
    e.pe = (($countones(d) + int'(p)) % 2) == 1;
    e.fe = !s;
    e.v  = !e.pe && !e.fe;
    exp_q.push_back(e);
  endtask
  task automatic drain(input string tag);
    rec_t g, e;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, g.d, e.d);
      check({tag, "_perr"}, g.pe, e.pe);
      check({tag, "_ferr"}, g.fe, e.fe);
      check({tag, "_valid"}, g.v, e.v);
    end
    got_q.delete();
    exp_q.delete();
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_perr"}, parity_err, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic          seen;
    logic [DW-1:0] d;
    logic          p, s;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    idle(5);
    send_frame(8'hA5, 1'b0, 1'b1);
    drain("t1_good");
    check("t1_busy_after", busy, 0);
    check("t1_hold", data_out, 8'hA5);
    idle(3);
    send_frame(8'h01, 1'b0, 1'b1);
    drain("t2_parity");
    send_frame(8'h03, 1'b0, 1'b1);
    drain("t2_recover");
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("t3_busy_low_held", busy, 0);
    idle(5);
    drain("t3_frame");
    rx = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("t4_busy_rise", seen, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    check("t4_busy_fall", seen, 1);
    idle(5);
    drain("t4_glitch");
    send_frame(8'h5A, 1'b0, 1'b1);
    drain("t4_after");
    idle(3);
    send_frame(8'hFF, 1'b0, 1'b1, 4);
    check("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check_zero("t5_async");
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(5);
    drain("t5_abort");
    send_frame(8'h81, 1'b0, 1'b1);
    drain("t5_after");
    send_frame(8'h12, ^8'h12, 1'b1);
    send_frame(8'h34, ^8'h34, 1'b1);
    send_frame(8'h56, ^8'h56, 1'b1);
    drain("t6_b2b");
    for (int n = 0; n < 40; n++) begin
      d = DW'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) != 0);
      send_frame(d, p, s);
      if (!s) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        idle(4 + $urandom_range(0, 6));
      end else begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      drain("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Receives serial frames from the team's parity-serial link: start bit, DATA_W data bits LSB first, even-parity bit, stop bit.
- Checks parity with an XNOR comparison of the received parity bit against the reduction-XOR of the data.
- Presents the received word with valid and error flags.
- Sits at the receive end of the link, opposite the serial parity transmitter, and feeds downstream logic directly.

Parameters:
- DATA_W, 8: number of data bits per frame (2..16).
- CLKS_PER_BIT, 16: clk cycles per bit period (even, ≥4).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data_out  output  DATA_W  last received word.
- done  output  1  one-cycle pulse when a frame completes, good or bad.
- valid  output  1  one-cycle pulse; equals done AND NOT parity_err AND NOT frame_err.
- parity_err  output  1  parity result for the last frame; updated with done; held until the next done.
- frame_err  output  1  stop-bit result for the last frame; updated with done; held until the next done.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - data_out = 0, done = 0, valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - FSM goes to IDLE; bit and cycle counters clear; synchronizer flops go to 1.
- Synchronizer: rx passes through a 2-flop synchronizer. All decisions use the synced value (rxs).
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - On rxs = 0 (the synced line was high in IDLE), clear the cycle counter and go to START.
- START:
  - Count CLKS_PER_BIT/2 cycles, then sample rxs.
  - If rxs = 0, clear the counter, clear the bit index, and go to DATA.
  - If rxs = 1, treat it as a glitch: return to IDLE with no done.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rxs into bit [index]; the first sample is bit 0.
  - After bit DATA_W-1, go to PARITY.
- PARITY:
  - After CLKS_PER_BIT cycles, sample rxs into pbit and go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rxs as the stop bit and go to DONE.
- DONE (one cycle):
  - done = 1.
  - data_out takes the shift register.
  - parity_err = NOT(XNOR(^data, pbit)). Even parity: ^data ^ pbit must be 0.
  - frame_err = (stop bit == 0).
  - valid follows the rule in Ports.
  - Next state is IDLE.
- Sampling point: every sample falls mid-bit. The sample for bit k (start = 0) is taken CLKS_PER_BIT/2 + k*CLKS_PER_BIT cycles after the synced falling edge is detected.
- Back-to-back frames: the return to IDLE happens mid-stop-bit. A start edge arriving immediately after the nominal stop period must be accepted.
- Frame error recovery: if the line is still low after DONE, IDLE waits for it to return high before accepting a new start. This prevents a false restart.
- Reset mid-frame: abort immediately. No done is produced, and the partial word is discarded.
- data_out, parity_err and frame_err change only in DONE.

Test Plan (DATA_W = 8, CLKS_PER_BIT = 16):
1. Good frame: send 0xA5 with parity 0 and stop 1 → one done pulse, valid = 1, data_out = 0xA5, parity_err = 0, frame_err = 0, busy low afterwards.
2. Parity error: send 0x01 with parity 0 → done = 1, valid = 0, parity_err = 1, frame_err = 0, data_out = 0x01. Follow with 0x03 with parity 0 → parity_err clears to 0 and valid = 1.
3. Framing error: send 0x3C with parity 0 and stop 0, then hold the line low for 20 cycles before releasing it → frame_err = 1, valid = 0, and no second done appears while the line is held low.
4. Glitch rejection: pulse rx low for 4 cycles → busy rises then falls, done never asserts, and the following 0x5A frame is received correctly.
5. Reset mid-frame: assert rst during bit 3 of a 0xFF frame → all outputs go to 0 asynchronously with no done. After reset is released, a 0x81 frame is received with valid = 1.
6. Back-to-back: send 0x12, 0x34, 0x56 with no idle gap → three valid pulses with data_out = 0x12, 0x34, 0x56 in order and no errors.
